// File: rtl/wb_select_stage.sv
// Registered MIPS write-back stage: N-source select, load lane alignment and extension, stall/flush handling.
// Optional macro WB_MISALIGN_EN adds the misalign output and suppresses writes for misaligned loads.
module wb_select_stage #(
  parameter int DATA_W     = 32,
  parameter int NUM_SRC    = 4,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  stall,
  input  logic                  flush,
  input  logic                  in_valid,
  input  logic [DATA_W-1:0]     read_data,
  input  logic [DATA_W-1:0]     ALUResult,
  input  logic [DATA_W-1:0]     pc_plus4,
  input  logic [DATA_W-1:0]     imm_data,
  input  logic [1:0]            controle,
  input  logic [1:0]            load_size,
  input  logic                  load_unsigned,
  input  logic [1:0]            byte_off,
  input  logic                  reg_write_in,
  input  logic [REG_ADDR_W-1:0] write_reg_in,
`ifdef WB_MISALIGN_EN
  output logic                  misalign,
`endif
  output logic [DATA_W-1:0]     escrita_dado,
  output logic [REG_ADDR_W-1:0] write_reg_out,
  output logic                  reg_write_out,
  output logic                  out_valid
);

  localparam logic [2:0] NUM_SRC_L = 3'(NUM_SRC);

  // Lanes always index the low 32 bits, even for wider datapaths.
  function automatic logic [DATA_W-1:0] extract_load(
    input logic [DATA_W-1:0] data,
    input logic [1:0]        size,
    input logic              uns,
    input logic [1:0]        off
  );
    logic [15:0]       half_v;
    logic [7:0]        byte_v;
    logic [DATA_W-1:0] res;
    half_v = off[1] ? data[31:16] : data[15:0];
    case (off)
      2'd0:    byte_v = data[7:0];
      2'd1:    byte_v = data[15:8];
      2'd2:    byte_v = data[23:16];
      2'd3:    byte_v = data[31:24];
      default: byte_v = data[7:0];
    endcase
    case (size)
      2'd1:    res = {{(DATA_W-16){~uns & half_v[15]}}, half_v};
      2'd2:    res = {{(DATA_W-8){~uns & byte_v[7]}}, byte_v};
      default: res = data;
    endcase
    return res;
  endfunction

  logic [DATA_W-1:0] sel_data_s;
  logic              wen_s;
`ifdef WB_MISALIGN_EN
  logic              misalign_s;
`endif

  // Write-back source mux; selects beyond NUM_SRC yield zero.
  always_comb begin
    sel_data_s = {DATA_W{1'b0}};
    if ({1'b0, controle} >= NUM_SRC_L) begin
      sel_data_s = {DATA_W{1'b0}};
    end else begin
      case (controle)
        2'd0:    sel_data_s = extract_load(read_data, load_size, load_unsigned, byte_off);
        2'd1:    sel_data_s = ALUResult;
        2'd2:    sel_data_s = pc_plus4;
        2'd3:    sel_data_s = imm_data;
        default: sel_data_s = {DATA_W{1'b0}};
      endcase
    end
  end

  // Write enable qualification; register $0 is never written.
  always_comb begin
    wen_s = reg_write_in & in_valid & (write_reg_in != {REG_ADDR_W{1'b0}});
  end

`ifdef WB_MISALIGN_EN
  // Reserved load_size 3 behaves as a word load.
  always_comb begin
    misalign_s = 1'b0;
    if (in_valid && (controle == 2'd0)) begin
      misalign_s = ((load_size == 2'd1) && byte_off[0]) ||
                   (((load_size == 2'd0) || (load_size == 2'd3)) && (byte_off != 2'd0));
    end else begin
      misalign_s = 1'b0;
    end
  end
`endif

  // MEM/WB pipeline register: flush beats stall; flush keeps data and destination.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      escrita_dado  <= {DATA_W{1'b0}};
      write_reg_out <= {REG_ADDR_W{1'b0}};
      reg_write_out <= 1'b0;
      out_valid     <= 1'b0;
`ifdef WB_MISALIGN_EN
      misalign      <= 1'b0;
`endif
    end else if (flush) begin
      reg_write_out <= 1'b0;
      out_valid     <= 1'b0;
`ifdef WB_MISALIGN_EN
      misalign      <= 1'b0;
`endif
    end else if (!stall) begin
      write_reg_out <= write_reg_in;
      out_valid     <= in_valid;
`ifdef WB_MISALIGN_EN
      misalign      <= misalign_s;
      escrita_dado  <= misalign_s ? {DATA_W{1'b0}} : sel_data_s;
      reg_write_out <= wen_s & ~misalign_s;
`else
      escrita_dado  <= sel_data_s;
      reg_write_out <= wen_s;
`endif
    end else begin
      escrita_dado  <= escrita_dado;
      write_reg_out <= write_reg_out;
      reg_write_out <= reg_write_out;
      out_valid     <= out_valid;
`ifdef WB_MISALIGN_EN
      misalign      <= misalign;
`endif
    end
  end

endmodule

// File: tb/tb_wb_select_stage.sv
// Scoreboard bench for wb_select_stage: driver pushes model predictions, monitor pops and compares.
// Two instances run in lockstep: NUM_SRC=4 and NUM_SRC=2 (the latter only its data output is checked).
module tb_wb_select_stage;

  logic        clk = 1'b0;
  logic        rst_n, stall, flush, in_valid, load_unsigned, reg_write_in;
  logic [31:0] read_data, ALUResult, pc_plus4, imm_data;
  logic [1:0]  controle, load_size, byte_off;
  logic [4:0]  write_reg_in;
  logic [31:0] escrita_dado, escrita_dado2;
  logic [4:0]  write_reg_out, write_reg_out2;
  logic        reg_write_out, reg_write_out2, out_valid, out_valid2;
`ifdef WB_MISALIGN_EN
  logic        misalign, misalign2;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  wb_select_stage #(.DATA_W(32), .NUM_SRC(4), .REG_ADDR_W(5)) u_dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush), .in_valid(in_valid),
    .read_data(read_data), .ALUResult(ALUResult), .pc_plus4(pc_plus4), .imm_data(imm_data),
    .controle(controle), .load_size(load_size), .load_unsigned(load_unsigned), .byte_off(byte_off),
    .reg_write_in(reg_write_in), .write_reg_in(write_reg_in),
`ifdef WB_MISALIGN_EN
    .misalign(misalign),
`endif
    .escrita_dado(escrita_dado), .write_reg_out(write_reg_out),
    .reg_write_out(reg_write_out), .out_valid(out_valid)
  );

  wb_select_stage #(.DATA_W(32), .NUM_SRC(2), .REG_ADDR_W(5)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush), .in_valid(in_valid),
    .read_data(read_data), .ALUResult(ALUResult), .pc_plus4(pc_plus4), .imm_data(imm_data),
    .controle(controle), .load_size(load_size), .load_unsigned(load_unsigned), .byte_off(byte_off),
    .reg_write_in(reg_write_in), .write_reg_in(write_reg_in),
`ifdef WB_MISALIGN_EN
    .misalign(misalign2),
`endif
    .escrita_dado(escrita_dado2), .write_reg_out(write_reg_out2),
    .reg_write_out(reg_write_out2), .out_valid(out_valid2)
  );

  typedef struct {
    logic [31:0] data;
    logic [31:0] data2;
    logic [4:0]  wreg;
    logic        wen;
    logic        valid;
    logic        mis;
  } exp_t;

  exp_t cur;
  exp_t q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Load extraction from the lane rules, using shifts and arithmetic.
  function automatic logic [31:0] ref_load(input logic [31:0] rd, input int sz, input logic uns, input int off);
    logic [31:0] v;
    if (sz == 1) begin
      v = (rd >> (16 * (off / 2))) & 32'h0000_FFFF;
      if (!uns && v >= 32'd32768) v = v + 32'hFFFF_0000;
    end else if (sz == 2) begin
      v = (rd >> (8 * off)) & 32'h0000_00FF;
      if (!uns && v >= 32'd128) v = v + 32'hFFFF_FF00;
    end else begin
      v = rd;
    end
    return v;
  endfunction

  function automatic logic [31:0] ref_sel(input int ctl, input int nsrc);
    if (ctl >= nsrc) return 32'd0;
    if (ctl == 0) return ref_load(read_data, int'(load_size), load_unsigned, int'(byte_off));
    if (ctl == 1) return ALUResult;
    if (ctl == 2) return pc_plus4;
    return imm_data;
  endfunction

  task automatic cyc(input logic st, input logic fl, input logic v, input logic [31:0] rd,
                     input logic [31:0] alu, input logic [31:0] pc, input logic [31:0] imm,
                     input logic [1:0] ctl, input logic [1:0] sz, input logic uns,
                     input logic [1:0] off, input logic rw, input logic [4:0] wr);
    bit mis;
    @(negedge clk);
    stall = st; flush = fl; in_valid = v; read_data = rd; ALUResult = alu; pc_plus4 = pc;
    imm_data = imm; controle = ctl; load_size = sz; load_unsigned = uns; byte_off = off;
    reg_write_in = rw; write_reg_in = wr;
    if (fl) begin
      cur.valid = 1'b0; cur.wen = 1'b0; cur.mis = 1'b0;
    end else if (!st) begin
      mis = 1'b0;
`ifdef WB_MISALIGN_EN
      mis = v && (ctl == 2'd0) && (((sz == 2'd1) && (off % 2 == 1)) || ((sz == 2'd0 || sz == 2'd3) && off != 2'd0));
`endif
      cur.valid = v;
      cur.wreg  = wr;
      cur.wen   = rw && v && (wr != 5'd0) && !mis;
      cur.mis   = mis;
      cur.data  = mis ? 32'd0 : ref_sel(int'(ctl), 4);
      cur.data2 = mis ? 32'd0 : ref_sel(int'(ctl), 2);
    end
    if (rst_n) q.push_back(cur);
  endtask

  task automatic after_edge();
    @(posedge clk); #2;
  endtask

  // Monitor: one prediction per clock edge, compared just after the edge.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("out_valid", {31'd0, out_valid}, {31'd0, e.valid});
      chk("reg_write_out", {31'd0, reg_write_out}, {31'd0, e.wen});
      chk("write_reg_out", {27'd0, write_reg_out}, {27'd0, e.wreg});
      chk("escrita_dado", escrita_dado, e.data);
      chk("escrita_dado_nsrc2", escrita_dado2, e.data2);
`ifdef WB_MISALIGN_EN
      chk("misalign", {31'd0, misalign}, {31'd0, e.mis});
`endif
    end
  end

  task automatic zero_model();
    cur.data = 32'd0; cur.data2 = 32'd0; cur.wreg = 5'd0;
    cur.wen = 1'b0; cur.valid = 1'b0; cur.mis = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_data"}, escrita_dado, 32'd0);
    chk({tag, "_wreg"}, {27'd0, write_reg_out}, 32'd0);
    chk({tag, "_wen"}, {31'd0, reg_write_out}, 32'd0);
    chk({tag, "_valid"}, {31'd0, out_valid}, 32'd0);
    chk({tag, "_data2"}, escrita_dado2, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] a_val;
    rst_n = 1'b0; stall = 1'b0; flush = 1'b0; in_valid = 1'b0; read_data = 32'd0;
    ALUResult = 32'd0; pc_plus4 = 32'd0; imm_data = 32'd0; controle = 2'd0; load_size = 2'd0;
    load_unsigned = 1'b0; byte_off = 2'd0; reg_write_in = 1'b0; write_reg_in = 5'd0;
    zero_model();
    repeat (2) @(posedge clk);
    #2 chk_reset_outputs("reset");
    @(negedge clk) rst_n = 1'b1;

    // Load valid data, then assert reset between edges.
    cyc(0, 0, 1, 32'd0, 32'hDEAD_BEEF, 32'd0, 32'd0, 2'd1, 2'd0, 0, 2'd0, 1, 5'd9);
    @(posedge clk); #3 rst_n = 1'b0;
    #1 chk_reset_outputs("async_reset");
    zero_model();
    @(negedge clk) rst_n = 1'b1;

    cyc(0, 0, 1, 32'd0, 32'h0000_1234, 32'd0, 32'd0, 2'd1, 2'd0, 0, 2'd0, 1, 5'd8);
    after_edge();
    chk("first_data", escrita_dado, 32'h0000_1234);
    chk("first_wen", {31'd0, reg_write_out}, 32'd1);
    chk("first_wreg", {27'd0, write_reg_out}, 32'd8);

    cyc(0, 0, 1, 32'h80FF_7F01, 32'd0, 32'd0, 32'd0, 2'd0, 2'd2, 0, 2'd1, 1, 5'd3);
    after_edge(); chk("byte_off1_s", escrita_dado, 32'h0000_007F);
    cyc(0, 0, 1, 32'h80FF_7F01, 32'd0, 32'd0, 32'd0, 2'd0, 2'd2, 0, 2'd3, 1, 5'd3);
    after_edge(); chk("byte_off3_s", escrita_dado, 32'hFFFF_FF80);
    cyc(0, 0, 1, 32'h80FF_7F01, 32'd0, 32'd0, 32'd0, 2'd0, 2'd1, 0, 2'd2, 1, 5'd3);
    after_edge(); chk("half_off2_s", escrita_dado, 32'hFFFF_80FF);
    cyc(0, 0, 1, 32'h80FF_7F01, 32'd0, 32'd0, 32'd0, 2'd0, 2'd1, 1, 2'd2, 1, 5'd3);
    after_edge(); chk("half_off2_u", escrita_dado, 32'h0000_80FF);

    cyc(0, 0, 1, 32'd0, 32'd0, 32'h0040_0008, 32'd0, 2'd2, 2'd0, 0, 2'd0, 1, 5'd31);
    after_edge(); chk("src_pc4", escrita_dado, 32'h0040_0008);
    cyc(0, 0, 1, 32'd0, 32'd0, 32'd0, 32'hABCD_0000, 2'd3, 2'd0, 0, 2'd0, 1, 5'd4);
    after_edge();
    chk("src_imm", escrita_dado, 32'hABCD_0000);
    chk("src_imm_nsrc2", escrita_dado2, 32'd0);

    cyc(0, 0, 1, 32'd0, 32'h0000_5555, 32'd0, 32'd0, 2'd1, 2'd0, 0, 2'd0, 1, 5'd0);
    after_edge();
    chk("zero_reg_wen", {31'd0, reg_write_out}, 32'd0);
    chk("zero_reg_valid", {31'd0, out_valid}, 32'd1);

    a_val = 32'hA5A5_0F0F;
    cyc(0, 0, 1, 32'd0, a_val, 32'd0, 32'd0, 2'd1, 2'd0, 0, 2'd0, 1, 5'd12);
    for (int i = 0; i < 3; i++) begin
      cyc(1, 0, $urandom_range(0, 1), $urandom, $urandom, $urandom, $urandom, 2'($urandom),
          2'($urandom), 1'($urandom), 2'($urandom), 1, 5'($urandom_range(1, 31)));
      after_edge(); chk("stall_hold", escrita_dado, a_val);
    end
    cyc(1, 1, 1, 32'd0, 32'h1111_1111, 32'd0, 32'd0, 2'd1, 2'd0, 0, 2'd0, 1, 5'd7);
    after_edge();
    chk("flush_valid", {31'd0, out_valid}, 32'd0);
    chk("flush_wen", {31'd0, reg_write_out}, 32'd0);

`ifdef WB_MISALIGN_EN
    cyc(0, 0, 1, 32'h1234_5678, 32'd0, 32'd0, 32'd0, 2'd0, 2'd0, 0, 2'd2, 1, 5'd5);
    after_edge();
    chk("mis_flag", {31'd0, misalign}, 32'd1);
    chk("mis_wen", {31'd0, reg_write_out}, 32'd0);
    chk("mis_data", escrita_dado, 32'd0);
    cyc(0, 0, 1, 32'h1234_5678, 32'd0, 32'd0, 32'd0, 2'd0, 2'd0, 0, 2'd0, 1, 5'd5);
    after_edge(); chk("mis_clear", {31'd0, misalign}, 32'd0);
`endif

    // Random traffic, mostly back-to-back captures with occasional stall/flush.
    for (int i = 0; i < 400; i++) begin
      cyc(1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 14) == 0), 1'($urandom_range(0, 3) != 0),
          $urandom, $urandom, $urandom, $urandom, 2'($urandom), 2'($urandom), 1'($urandom),
          2'($urandom), 1'($urandom), 5'($urandom_range(0, 5) == 0 ? 0 : $urandom_range(1, 31)));
    end

    @(posedge clk); #3;
    chk("queue_drained", q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
